// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared mode encoding, PC step constants and prefetch queue entry
package fetch_pkg;

  typedef enum logic {
    MODE_ARM   = 1'b0,
    MODE_THUMB = 1'b1
  } mode_t;

  localparam int unsigned PC_STEP_ARM   = 4;
  localparam int unsigned PC_STEP_THUMB = 2;

  // Entry fields are sized for the widest build; narrower tops zero-extend into them.
  localparam int unsigned ENTRY_DATA_W = 64;
  localparam int unsigned ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] instr;
    logic [ENTRY_ADDR_W-1:0] pc;
    mode_t                   mode;
  } fetch_entry_t;

  function automatic int unsigned pc_step(mode_t m);
    return (m == MODE_THUMB) ? PC_STEP_THUMB : PC_STEP_ARM;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch entry queue with flush and wrap-around pointers
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Storage is cleared on reset so the head reads as all-zero until the first push.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetcher: one outstanding read feeding a DEPTH-entry queue
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  output logic                       MEM_REQ,
  output logic [ADDR_W-1:0]          MEM_ADDR,
  input  logic                       MEM_ACK,
  input  logic [DATA_W-1:0]          MEM_RDATA,
  input  logic                       REDIRECT,
  input  logic [ADDR_W-1:0]          REDIRECT_PC,
  input  logic                       THUMB,
  output logic [DATA_W-1:0]          IR,
  output logic [ADDR_W-1:0]          IR_PC,
  output logic                       IR_THUMB,
  output logic                       FETCH_EN,
  input  logic                       IR_READY,
  output logic [$clog2(DEPTH):0]     COUNT
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  mode_t             mode;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] instr;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              head_unused;

  // Dropping MEM_REQ cancels the access, so an ACK only counts while we are requesting.
  assign MEM_REQ  = RESET_N && !REDIRECT && (COUNT < CNT_W'(DEPTH));
  assign MEM_ADDR = {pc[ADDR_W-1:2], 2'b00};
  assign push     = MEM_REQ && MEM_ACK;
  assign pop      = FETCH_EN && IR_READY && !REDIRECT;

  always_comb begin
    instr = MEM_RDATA;
    if (mode == MODE_THUMB) instr = DATA_W'(pc[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0]);
  end

  assign push_entry = '{instr: ENTRY_DATA_W'(instr), pc: ENTRY_ADDR_W'(pc), mode: mode};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc   <= RESET_PC;
      mode <= MODE_ARM;
    end else if (REDIRECT) begin
      pc   <= THUMB ? {REDIRECT_PC[ADDR_W-1:1], 1'b0} : {REDIRECT_PC[ADDR_W-1:2], 2'b00};
      mode <= mode_t'(THUMB);
    end else if (push) begin
      pc   <= pc + ADDR_W'(pc_step(mode));
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push),
    .wdata   (push_entry),
    .pop     (pop),
    .flush   (REDIRECT),
    .head    (head),
    .count   (COUNT)
  );

  assign IR          = head.instr[DATA_W-1:0];
  assign IR_PC       = head.pc[ADDR_W-1:0];
  assign IR_THUMB    = (head.mode == MODE_THUMB);
  assign FETCH_EN    = (COUNT != '0);
  assign head_unused = ^head;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 10'h000;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b1;
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_ACK;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              REDIRECT = 1'b0;
  logic [ADDR_W-1:0] REDIRECT_PC = '0;
  logic              THUMB = 1'b0;
  logic [DATA_W-1:0] IR;
  logic [ADDR_W-1:0] IR_PC;
  logic              IR_THUMB;
  logic              FETCH_EN;
  logic              IR_READY = 1'b0;
  logic [2:0]        COUNT;

  fetch_prefetch_queue #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_ACK     (MEM_ACK),
    .MEM_RDATA   (MEM_RDATA),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .THUMB       (THUMB),
    .IR          (IR),
    .IR_PC       (IR_PC),
    .IR_THUMB    (IR_THUMB),
    .FETCH_EN    (FETCH_EN),
    .IR_READY    (IR_READY),
    .COUNT       (COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: word i holds {B000|i, A000|i}; ACK after lat waiting cycles, cancelled when MEM_REQ drops.
  logic [31:0] mem_img [256];
  int          lat = 0;
  int          wait_cnt = 0;
  logic        force_ack = 1'b0;

  assign MEM_ACK   = force_ack || (MEM_REQ && (wait_cnt >= lat));
  assign MEM_RDATA = MEM_ACK ? mem_img[MEM_ADDR[9:2]] : 32'hDEAD_BEEF;

  always @(posedge CLK) begin
    if (!MEM_REQ || MEM_ACK) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  // Reference model: expected instruction stream as a plain queue.
  typedef struct {
    logic [31:0] instr;
    logic [9:0]  pc;
    logic        thumb;
  } ref_t;

  ref_t        q[$];
  logic [9:0]  m_pc = RESET_PC;
  logic        m_thumb = 1'b0;

  always @(negedge CLK) begin
    logic        exp_req;
    logic [31:0] w;
    ref_t        e;
    if (!RESET_N) begin
      q.delete();
      m_pc    = RESET_PC;
      m_thumb = 1'b0;
      check("m_rst_en",    64'(FETCH_EN), 64'(0));
      check("m_rst_req",   64'(MEM_REQ),  64'(0));
      check("m_rst_count", 64'(COUNT),    64'(0));
      check("m_rst_ir",    64'(IR),       64'(0));
      check("m_rst_irpc",  64'(IR_PC),    64'(0));
      check("m_rst_thumb", 64'(IR_THUMB), 64'(0));
    end else begin
      exp_req = (q.size() < DEPTH) && !REDIRECT;
      check("m_count", 64'(COUNT),    64'(q.size()));
      check("m_en",    64'(FETCH_EN), 64'(q.size() != 0));
      check("m_req",   64'(MEM_REQ),  64'(exp_req));
      check("m_addr",  64'(MEM_ADDR), 64'({m_pc[9:2], 2'b00}));
      if (q.size() != 0) begin
        check("m_ir",    64'(IR),       64'(q[0].instr));
        check("m_irpc",  64'(IR_PC),    64'(q[0].pc));
        check("m_thumb", 64'(IR_THUMB), 64'(q[0].thumb));
      end
      if (REDIRECT) begin
        q.delete();
        m_thumb = THUMB;
        m_pc    = THUMB ? (REDIRECT_PC & 10'h3FE) : (REDIRECT_PC & 10'h3FC);
      end else begin
        if (q.size() != 0 && IR_READY) void'(q.pop_front());
        if (exp_req && MEM_ACK) begin
          w       = mem_img[m_pc[9:2]];
          e.instr = !m_thumb ? w : (m_pc[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]});
          e.pc    = m_pc;
          e.thumb = m_thumb;
          q.push_back(e);
          m_pc    = m_pc + (m_thumb ? 10'd2 : 10'd4);
        end
      end
    end
  end

  typedef struct {
    logic       ready;
    logic       req;
    logic [9:0] addr;
    logic       en;
    logic [9:0] irpc;
    logic [2:0] cnt;
  } vec_t;

  vec_t vec [10];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = {16'hB000 | 16'(i), 16'hA000 | 16'(i)};

    // Streaming from reset, then stall until full, one pop, refill.
    vec[0] = '{1'b1, 1'b1, 10'h000, 1'b0, 10'h000, 3'd0};
    vec[1] = '{1'b1, 1'b1, 10'h004, 1'b1, 10'h000, 3'd1};
    vec[2] = '{1'b1, 1'b1, 10'h008, 1'b1, 10'h004, 3'd1};
    vec[3] = '{1'b0, 1'b1, 10'h00C, 1'b1, 10'h008, 3'd1};
    vec[4] = '{1'b0, 1'b1, 10'h010, 1'b1, 10'h008, 3'd2};
    vec[5] = '{1'b0, 1'b1, 10'h014, 1'b1, 10'h008, 3'd3};
    vec[6] = '{1'b0, 1'b0, 10'h018, 1'b1, 10'h008, 3'd4};
    vec[7] = '{1'b1, 1'b0, 10'h018, 1'b1, 10'h008, 3'd4};
    vec[8] = '{1'b0, 1'b1, 10'h018, 1'b1, 10'h00C, 3'd3};
    vec[9] = '{1'b0, 1'b0, 10'h01C, 1'b1, 10'h00C, 3'd4};

    #2 RESET_N = 1'b0;
    repeat (2) cyc();
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      IR_READY = vec[i].ready;
      @(negedge CLK);
      check("vec_req",   64'(MEM_REQ),  64'(vec[i].req));
      check("vec_addr",  64'(MEM_ADDR), 64'(vec[i].addr));
      check("vec_en",    64'(FETCH_EN), 64'(vec[i].en));
      check("vec_irpc",  64'(IR_PC),    64'(vec[i].irpc));
      check("vec_count", 64'(COUNT),    64'(vec[i].cnt));
      cyc();
    end

    // Thumb redirect with a colliding ACK and IR_READY, queue full.
    REDIRECT = 1'b1; REDIRECT_PC = 10'h102; THUMB = 1'b1; force_ack = 1'b1; IR_READY = 1'b1;
    @(negedge CLK);
    check("redir_req", 64'(MEM_REQ), 64'(0));
    cyc();
    REDIRECT = 1'b0; force_ack = 1'b0; IR_READY = 1'b0;
    @(negedge CLK);
    check("redir_count", 64'(COUNT),    64'(0));
    check("redir_en",    64'(FETCH_EN), 64'(0));
    check("redir_addr",  64'(MEM_ADDR), 64'(10'h100));
    check("redir_req2",  64'(MEM_REQ),  64'(1));
    cyc();
    IR_READY = 1'b1;
    @(negedge CLK);
    check("thumb_ir_hi", 64'(IR),       64'(32'h0000_B040));
    check("thumb_irpc1", 64'(IR_PC),    64'(10'h102));
    check("thumb_mode",  64'(IR_THUMB), 64'(1));
    check("thumb_addr",  64'(MEM_ADDR), 64'(10'h104));
    cyc();
    @(negedge CLK);
    check("thumb_irpc2", 64'(IR_PC), 64'(10'h104));
    check("thumb_ir_lo", 64'(IR),    64'(32'h0000_A041));
    cyc();

    // ARM PC wrap at the top of the address space.
    REDIRECT = 1'b1; REDIRECT_PC = 10'h3FE; THUMB = 1'b0;
    @(negedge CLK);
    cyc();
    REDIRECT = 1'b0;
    @(negedge CLK);
    check("wrap_addr0", 64'(MEM_ADDR), 64'(10'h3FC));
    cyc();
    @(negedge CLK);
    check("wrap_addr1", 64'(MEM_ADDR), 64'(10'h000));
    check("wrap_irpc",  64'(IR_PC),    64'(10'h3FC));
    check("wrap_ir",    64'(IR),       64'(32'hB0FF_A0FF));
    cyc();

    // Slow memory with IR_READY toggling, then mixed latency with random redirects.
    lat = 3;
    for (int i = 0; i < 600; i++) begin
      IR_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      cyc();
    end
    for (int i = 0; i < 900; i++) begin
      lat         = int'($urandom_range(0, 3));
      IR_READY    = 1'($urandom_range(0, 1));
      REDIRECT    = ($urandom_range(0, 24) == 0);
      REDIRECT_PC = 10'($urandom);
      THUMB       = 1'($urandom_range(0, 1));
      @(negedge CLK);
      cyc();
    end

    // Fill to three entries, then reset asynchronously mid-cycle.
    lat = 0; IR_READY = 1'b0; REDIRECT = 1'b1; REDIRECT_PC = 10'h000; THUMB = 1'b0;
    @(negedge CLK);
    cyc();
    REDIRECT = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      cyc();
    end
    @(negedge CLK);
    check("pre_rst_count", 64'(COUNT), 64'(3));
    cyc();
    RESET_N = 1'b0; force_ack = 1'b1;
    #1;
    check("rst_en_now",    64'(FETCH_EN), 64'(0));
    check("rst_count_now", 64'(COUNT),    64'(0));
    check("rst_req_now",   64'(MEM_REQ),  64'(0));
    check("rst_ir_now",    64'(IR),       64'(0));
    @(negedge CLK);
    cyc();
    @(negedge CLK);
    cyc();
    RESET_N = 1'b1; force_ack = 1'b0;
    @(negedge CLK);
    check("restart_req",  64'(MEM_REQ),  64'(1));
    check("restart_addr", 64'(MEM_ADDR), 64'(RESET_PC));
    check("restart_en",   64'(FETCH_EN), 64'(0));
    cyc();
    @(negedge CLK);
    check("restart_en1",  64'(FETCH_EN), 64'(1));
    check("restart_irpc", 64'(IR_PC),    64'(RESET_PC));
    check("restart_ir",   64'(IR),       64'(32'hB000_A000));
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
